// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/sub datapath.
package addsub_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of 4-bit nibbles needed to cover a WIDTH-bit word.
  function automatic int nibs_f(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/fasrip.sv
// 4-bit ripple add/sub slice: s = a + (b ^ {4{s_op}}) + cin.
module fasrip #(
  parameter int Tpd = 1
) (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       s_op,
  output logic [3:0] s,
  output logic       cout
);

  // Tpd only describes the legacy behavioural model's delay; the
  // synthesizable slice is zero-delay, so just reject nonsense values.
  if (Tpd < 0) begin : g_bad_tpd
    $error("fasrip: Tpd must be non-negative");
  end

  logic [3:0] be;
  logic [4:0] c;

  assign be   = b ^ {4{s_op}};
  assign c[0] = cin;

  // Full-adder ripple chain, bit 0 up to bit 3.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ be[i] ^ c[i];
    assign c[i+1] = (a[i] & be[i]) | (c[i] & (a[i] ^ be[i]));
  end

  assign cout = c[4];

endmodule

// File: rtl/nibble_addsub_seq.sv
// Nibble-serial WIDTH-bit add/sub built from one reused 4-bit fasrip slice.
// Carry is carried between nibbles in a register so the combinational
// path never exceeds one 4-bit ripple.
module nibble_addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int Tpd   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NIBS  = nibs_f(WIDTH);
  localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBS - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
    $error("nibble_addsub_seq: WIDTH must be a multiple of 4, minimum 4");
  end

  logic [1:0]                 state;
  logic [IDX_W-1:0]           idx;
  logic                       carry;
  logic                       op_r;
  logic [NIBS-1:0][NIB_W-1:0] a_r, b_r, s_r;
  logic [NIB_W-1:0]           sl_s;
  logic                       sl_co;
  logic                       ovf_nxt;

  assign in_ready  = (state == S_IDLE) & ~rst;
  assign out_valid = (state == S_DONE);
  assign s         = s_r;

  fasrip #(.Tpd(Tpd)) u_slice (
    .a    (a_r[idx]),
    .b    (b_r[idx]),
    .cin  (carry),
    .s_op (op_r),
    .s    (sl_s),
    .cout (sl_co)
  );

  // Signed overflow: operands agree in sign but result sign differs. The
  // effective B sign accounts for the inversion applied on subtract.
  assign ovf_nxt = (a_r[NIBS-1][NIB_W-1] == (b_r[NIBS-1][NIB_W-1] ^ op_r)) &
                   (sl_s[NIB_W-1] != a_r[NIBS-1][NIB_W-1]);

  // Control FSM plus nibble datapath; flags are latched on the last nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_r  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      s_r   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            op_r  <= op;
            carry <= op;   // +1 of the two's-complement negate
            idx   <= '0;
            s_r   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          s_r[idx] <= sl_s;
          carry    <= sl_co;
          idx      <= idx + 1'b1;
          if (idx == LAST) begin
            state <= S_DONE;
            cout  <= sl_co;
            ovf   <= ovf_nxt;
            // Upper nibbles are still cleared, so the word is zero iff the
            // nibbles written so far and this last one are all zero.
            zero  <= (s_r == '0) && (sl_s == '0);
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_addsub_seq.sv
// Directed bench for nibble_addsub_seq (WIDTH=16).
module tb_nibble_addsub_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         op;
  logic         out_valid, out_ready;
  logic [W-1:0] s;
  logic         cout, ovf, zero;

  int n_chk  = 0;
  int n_fail = 0;

  nibble_addsub_seq #(.WIDTH(W), .Tpd(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands at negedge, hold through the accept edge, then drop.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic top);
    @(negedge clk);
    a = ta; b = tb_; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, ".out_valid_after"}, 32'(out_valid), 32'd0);
    chk({name, ".in_ready_after"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    int lat;
    logic [W-1:0] s_hold;

    vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0;
    #1;
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.s",         32'(s),         32'd0);
    chk("rst.flags",     32'({cout, ovf, zero}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].op);
      wait_done(lat);
      chk($sformatf("v%0d.latency", i), 32'(lat),  32'd4);
      chk($sformatf("v%0d.s", i),       32'(s),    32'(vecs[i].s));
      chk($sformatf("v%0d.cout", i),    32'(cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d.ovf", i),     32'(ovf),  32'(vecs[i].ovf));
      chk($sformatf("v%0d.zero", i),    32'(zero), 32'(vecs[i].zero));
      retire($sformatf("v%0d", i));
    end

    // Backpressure with operand toggling and stray in_valid in DONE
    start_op(16'h1234, 16'h0FCD, 1'b0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = W'($urandom); b = W'($urandom); op = ~op;
      @(posedge clk); #1;
      lat++;
    end
    chk("bp.latency", 32'(lat), 32'd4);
    s_hold = s;
    chk("bp.s", 32'(s), 32'h2201);
    for (int k = 0; k < 10; k++) begin
      a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("bp.hold%0d.in_ready", k),  32'(in_ready),  32'd0);
      chk($sformatf("bp.hold%0d.s", k),         32'(s),         32'(s_hold));
      chk($sformatf("bp.hold%0d.flags", k),     32'({cout, ovf, zero}), 32'd0);
    end
    in_valid = 1'b0;
    retire("bp");
    chk("bp.s_retained", 32'(s), 32'h2201);

    // Reset in the middle of RUN, after two nibbles
    start_op(16'h1234, 16'h0FCD, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid.partial_s", 32'(s), 32'h0001);
    rst = 1'b1;
    #1;
    chk("mid.s",         32'(s),         32'd0);
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.in_ready",  32'(in_ready),  32'd0);
    chk("mid.flags",     32'({cout, ovf, zero}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid.in_ready_rel", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("mid.no_result", 32'(out_valid), 32'd0);
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_done(lat);
    chk("post.latency", 32'(lat), 32'd4);
    chk("post.s",       32'(s),   32'h0002);
    chk("post.flags",   32'({cout, ovf, zero}), 32'd0);
    retire("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
